// File: rtl/mux4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux4_pkg
// Description : Select-code and leg-count constants shared by the mux4 slice.
// Revision    : 1.0 - initial release
// ============================================================================
package mux4_pkg;

    localparam int N_LEGS = 4;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_LEG0 = 2'b00;
    localparam sel_t SEL_LEG1 = 2'b01;
    localparam sel_t SEL_LEG2 = 2'b10;
    localparam sel_t SEL_LEG3 = 2'b11;

endpackage : mux4_pkg
`default_nettype wire

// File: rtl/mux4_sel.sv
`default_nettype none
// ============================================================================
// Module      : mux4_sel
// Description : Combinational leg extraction and 4:1 selection.
// Revision    : 1.0 - initial release
// ============================================================================
module mux4_sel
    import mux4_pkg::*;
#(
    parameter int DATA_W = 1
) (
    input  logic [N_LEGS*DATA_W-1:0] i_a,
    input  sel_t                     i_s,
    output logic [DATA_W-1:0]        o_leg
);

    logic [DATA_W-1:0] w_legs [N_LEGS];

    for (genvar k = 0; k < N_LEGS; k++) begin : g_leg
        assign w_legs[k] = i_a[k*DATA_W +: DATA_W];
    end

    // Every select code maps to a real leg; nothing falls back to zero.
    always_comb begin
        o_leg = w_legs[0];
        case (i_s)
            SEL_LEG0: o_leg = w_legs[0];
            SEL_LEG1: o_leg = w_legs[1];
            SEL_LEG2: o_leg = w_legs[2];
            SEL_LEG3: o_leg = w_legs[3];
        endcase
    end

endmodule : mux4_sel
`default_nettype wire

// File: rtl/mux4.sv
`default_nettype none
// ============================================================================
// Module      : mux4
// Description : Registered 4:1 multiplexer with synchronous active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
module mux4
    import mux4_pkg::*;
#(
    parameter int DATA_W = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_LEGS*DATA_W-1:0] a,
    input  logic [1:0]               s,
    output logic [DATA_W-1:0]        y
);

    logic [DATA_W-1:0] w_sel;
    logic [DATA_W-1:0] r_y;

    mux4_sel #(
        .DATA_W (DATA_W)
    ) u_sel (
        .i_a   (a),
        .i_s   (s),
        .o_leg (w_sel)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y <= '0;
        end else begin
            r_y <= w_sel;
        end
    end

    assign y = r_y;

endmodule : mux4
`default_nettype wire

// File: tb/tb_mux4.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux4
// Description : Self-checking bench for mux4 against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux4;

    localparam int DATA_W = 1;

    logic              clk;
    logic              rst;
    logic [4*DATA_W-1:0] a;
    logic [1:0]        s;
    logic [DATA_W-1:0] y;

    int total = 0;
    int bad   = 0;

    mux4 #(
        .DATA_W (DATA_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .s   (s),
        .y   (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: leg s is the s-th DATA_W-wide chunk counted from the LSB.
    function automatic logic [DATA_W-1:0] ref_y(input logic r,
                                                input logic [4*DATA_W-1:0] av,
                                                input logic [1:0] sv);
        int unsigned shift;
        logic [4*DATA_W-1:0] t;
        if (r) return '0;
        shift = int'(sv) * DATA_W;
        t = av >> shift;
        return t[DATA_W-1:0];
    endfunction

    // Drive one cycle of inputs, advance past the edge, leave time to sample.
    task automatic step(input logic r, input logic [4*DATA_W-1:0] av, input logic [1:0] sv);
        rst = r;
        a   = av;
        s   = sv;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [DATA_W-1:0] exp;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 4'b1111, 2'b11);
            exp = ref_y(1'b1, 4'b1111, 2'b11);
            total++;
            if (y !== exp) begin
                bad++;
                $display("FAIL reset_edge%0d: y=%b expected=%b", i, y, exp);
            end
        end
        step(1'b0, 4'b1111, 2'b11);
        exp = ref_y(1'b0, 4'b1111, 2'b11);
        total++;
        if (y !== exp) begin
            bad++;
            $display("FAIL reset_release: y=%b expected=%b", y, exp);
        end
    endtask

    task automatic test_sweep(input string name, input logic [4*DATA_W-1:0] av);
        logic [DATA_W-1:0] exp;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, av, 2'(k));
            exp = ref_y(1'b0, av, 2'(k));
            total++;
            if (y !== exp) begin
                bad++;
                $display("FAIL %s a=%b s=%0d: y=%b expected=%b", name, av, k, y, exp);
            end
        end
    endtask

    task automatic test_directed();
        logic [4*DATA_W-1:0] av [4];
        logic [1:0]          sv [4];
        logic [DATA_W-1:0]   ev [4];
        av = '{4'b0101, 4'b1010, 4'b1010, 4'b0101};
        sv = '{2'b01, 2'b10, 2'b01, 2'b00};
        ev = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            step(1'b0, av[i], sv[i]);
            total++;
            if (y !== ev[i]) begin
                bad++;
                $display("FAIL directed%0d a=%b s=%b: y=%b expected=%b", i, av[i], sv[i], y, ev[i]);
            end
        end
    endtask

    // Inputs changing between edges must not reach y before the next edge.
    task automatic test_hold();
        logic [DATA_W-1:0] held;
        step(1'b0, 4'b0001, 2'b00);
        held = ref_y(1'b0, 4'b0001, 2'b00);
        for (int i = 0; i < 3; i++) begin
            a = 4'($urandom_range(0, 15)) & 4'b1110;
            s = 2'($urandom_range(1, 3));
            #1;
            total++;
            if (y !== held) begin
                bad++;
                $display("FAIL hold%0d: y=%b expected=%b", i, y, held);
            end
        end
        @(posedge clk);
        #1;
        total++;
        if (y !== ref_y(1'b0, a, s)) begin
            bad++;
            $display("FAIL hold_load: y=%b expected=%b", y, ref_y(1'b0, a, s));
        end
    endtask

    // Toggle every unselected leg while keeping the selected one fixed.
    task automatic test_unselected();
        logic [4*DATA_W-1:0] av;
        logic [4*DATA_W-1:0] mask;
        logic [1:0]          sv;
        logic [DATA_W-1:0]   first;
        for (int i = 0; i < 4; i++) begin
            sv = 2'(i);
            av = 4'($urandom_range(0, 15));
            step(1'b0, av, sv);
            first = ref_y(1'b0, av, sv);
            mask = ~(4'b0001 << sv);
            step(1'b0, av ^ mask, sv);
            total++;
            if (y !== first) begin
                bad++;
                $display("FAIL unselected s=%0d: y=%b expected=%b", i, y, first);
            end
        end
    endtask

    task automatic test_random();
        logic [4*DATA_W-1:0] av;
        logic                r;
        logic [DATA_W-1:0]   exp;
        for (int v = 0; v < 5; v++) begin
            av = 4'($urandom_range(0, 15));
            for (int k = 0; k < 4; k++) begin
                r = (v == 2 && k == 1);
                step(r, av, 2'(k));
                exp = ref_y(r, av, 2'(k));
                total++;
                if (y !== exp) begin
                    bad++;
                    $display("FAIL random v=%0d a=%b s=%0d rst=%b: y=%b expected=%b",
                             v, av, k, r, y, exp);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4*DATA_W-1:0] av;
        logic [1:0]          sv;
        logic [DATA_W-1:0]   exp;
        for (int i = 0; i < 16; i++) begin
            av = 4'($urandom_range(0, 15));
            sv = 2'($urandom_range(0, 3));
            step(1'b0, av, sv);
            exp = ref_y(1'b0, av, sv);
            total++;
            if (y !== exp) begin
                bad++;
                $display("FAIL back_to_back%0d a=%b s=%b: y=%b expected=%b", i, av, sv, y, exp);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        a   = '0;
        s   = '0;
        test_reset();
        test_sweep("zero", 4'b0000);
        test_sweep("mixed", 4'b1100);
        test_sweep("ones", 4'b1111);
        test_directed();
        test_hold();
        test_unselected();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mux4
`default_nettype wire

// File: doc/mux4.md
MUX4 -- requirements
Module: mux4

Interface
- Parameters:
  - REQ-001: DATA_W, default 1, width of each of the four data legs.
- Ports, in order:
  - REQ-002: clk  input  1  single clock; all state updates on rising edge; reset is synchronous and active-high.
  - REQ-003: rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
  - REQ-004: a  input  4*DATA_W  four data legs packed; leg k = a[k*DATA_W +: DATA_W], leg 0 in the LSBs.
  - REQ-005: s  input  2  leg select, unsigned binary: 00 leg 0, 01 leg 1, 10 leg 2, 11 leg 3.
  - REQ-006: y  output  DATA_W  registered selected leg.

Function
- REQ-007: On each rising clk edge with rst=0, y SHALL load leg s of a, as sampled at that edge.
- REQ-008: Latency from a/s change to y SHALL be exactly one clk cycle; no combinational path from a or s to y.
- REQ-009: When both a and s change before the same edge, y SHALL reflect the new a indexed by the new s.
- REQ-010: y SHALL hold its value between edges regardless of activity on a or s.
- REQ-011: All four select codes SHALL be valid; there is no illegal or default-to-zero select case.
- REQ-012: Only the selected leg SHALL influence y; changes on unselected legs SHALL leave y unchanged at the next edge.
- REQ-013: For DATA_W=1 the block SHALL behave as y(n+1) = a[s] sampled at cycle n.
- REQ-014: The select decode SHALL be a pure function of s with no internal state.

Reset
- REQ-015: When rst=1 at a rising clk edge, y SHALL become all zeros, overriding a and s.
- REQ-016: Reset SHALL have no asynchronous effect; y changes only on clk edges.
- REQ-017: On the first edge after rst deasserts, y SHALL load leg s of a per REQ-007; no extra idle cycle.
- REQ-018: If rst asserts mid-stream, y SHALL be zero after that edge, and the pre-reset selection SHALL NOT be retained.

Structure
- REQ-019: A shared package mux4_pkg SHALL hold:
  - the select-code constants SEL_LEG0..SEL_LEG3 (2'b00..2'b11);
  - the leg count constant N_LEGS=4.
- REQ-020: A single combinational sub-module, mux4_sel, SHALL perform leg extraction and selection (a, s -> selected leg).
- REQ-021: The top module mux4 SHALL contain only the mux4_sel instance and the output register with synchronous reset.

Verification
- REQ-022: Reset check:
  - Stimulus: rst=1 for 2 edges with a=4'b1111, s=2'b11.
  - Required response: y=0 after each edge.
  - Then: rst=0, and y=1 after the next edge.
- REQ-023: Zero input: a=4'b0000; sweep s=00,01,10,11, one edge each; y=0 every cycle.
- REQ-024: Mixed input: a=4'b1100; sweep s=00,01,10,11; y=0,0,1,1 one cycle after each select.
- REQ-025: All-ones input: a=4'b1111; sweep all s; y=1 for every select after one cycle.
- REQ-026: Directed pairs, each for one edge, in order:
  - a=4'b0101, s=01 -> y=0.
  - a=4'b1010, s=10 -> y=0.
  - a=4'b1010, s=01 -> y=1.
  - a=4'b0101, s=00 -> y=1.
- REQ-027: Random check: 5 random values of a, each swept over all four s values.
  - Compare y each cycle against a[s] from the previous cycle.
  - Assert rst once mid-sweep and check y=0 after that edge.
